// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and frame byte order.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } load_state_t;

  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  // Words arrive MSB first, so each new byte enters at the bottom and older bytes move up.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] data);
    return {word[23:0], data};
  endfunction

endpackage

// File: rtl/inst_loader_timeout.sv
// Idle-cycle watchdog: counts cycles without a byte while enabled, flags when TIMEOUT is reached.
module inst_loader_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt_reg;

  // Fires during the TIMEOUT-th consecutive idle cycle so the FSM aborts on that edge.
  assign expired = enable && !clear && (idle_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_reg <= '0;
    end else if (clear || !enable) begin
      idle_cnt_reg <= '0;
    end else if (!expired) begin
      idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Receives a length-prefixed program image over a byte stream and writes it word by word
// into instruction RAM, holding the CPU in reset until the image is complete.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        load_start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  load_state_t      state_reg;
  logic [15:0]      word_cnt_reg;
  logic [IDX_W-1:0] word_idx_reg;
  logic [1:0]       byte_idx_reg;
  logic [31:0]      word_buf_reg;

  logic [15:0]      len_full;
  logic [31:0]      word_full;
  logic             last_word;
  logic             timeout_clear;
  logic             timeout_enable;
  logic             timeout_expired;

  assign len_full  = {word_cnt_reg[15:8], rx_data};
  assign word_full = shift_in_byte(word_buf_reg, rx_data);
  assign last_word = ((16'(word_idx_reg) + 16'd1) == word_cnt_reg);

  // Only a frame that has started but not finished is subject to the idle abort.
  assign timeout_clear  = rx_valid | load_start;
  assign timeout_enable = (state_reg == S_LEN_LO) || (state_reg == S_DATA);

  inst_loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (timeout_clear),
    .enable  (timeout_enable),
    .expired (timeout_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_LEN_HI;
      word_cnt_reg <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      word_buf_reg <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (load_start) begin
        // Re-arming takes priority over any byte arriving in the same cycle.
        state_reg    <= S_LEN_HI;
        word_cnt_reg <= '0;
        word_idx_reg <= '0;
        byte_idx_reg <= '0;
        word_buf_reg <= '0;
        cpu_hold     <= 1'b1;
        load_done    <= 1'b0;
        load_err     <= 1'b0;
      end else begin
        case (state_reg)
          S_LEN_HI: begin
            if (rx_valid) begin
              word_cnt_reg <= {rx_data, 8'h00};
              state_reg    <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (rx_valid) begin
              word_cnt_reg <= len_full;
              word_idx_reg <= '0;
              byte_idx_reg <= '0;
              if (len_full == 16'd0) begin
                state_reg <= S_DONE;
              end else if (len_full > 16'(MAX_WORDS)) begin
                state_reg <= S_ERR;
              end else begin
                state_reg <= S_DATA;
              end
            end else if (timeout_expired) begin
              state_reg <= S_ERR;
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              word_buf_reg <= word_full;
              if (byte_idx_reg == LAST_BYTE_IDX) begin
                mem_we       <= 1'b1;
                mem_addr     <= {{(30 - IDX_W){1'b0}}, word_idx_reg, 2'b00};
                mem_wdata    <= word_full;
                byte_idx_reg <= '0;
                // The index stops on the final word so it can never wrap past capacity.
                if (last_word) begin
                  state_reg <= S_DONE;
                end else begin
                  word_idx_reg <= word_idx_reg + IDX_W'(1);
                end
              end else begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
              end
            end else if (timeout_expired) begin
              state_reg <= S_ERR;
            end
          end
          S_DONE: begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end
          S_ERR: begin
            load_err <= 1'b1;
            cpu_hold <= 1'b1;
          end
          default: begin
            state_reg <= S_LEN_HI;
          end
        endcase
      end
    end
  end

endmodule
